adder_operand_driver: RTL and testbench

- Initiator side of the combinational adder interface: generates operand pairs A/B, waits a settle interval, then samples sum X and checks it against a self-computed expected value.
- Sits beside the adder core in the sim/protocol harness and reports pass/fail plus the error count.
- Gives the cocotb bench a self-checking hardware-side counterpart to the adder.

---
 rtl/adder_operand_driver.sv | 127 ++++++++++++
 tb/tb_adder_operand_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_driver.sv
// Stimulus/check engine for a combinational adder: drives A/B and compares X against A+B.
// Optional simulation logging is compiled in with the ADDER_DRIVER_LOG_EN macro.
module adder_operand_driver #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned CW = $clog2(NUM_VECTORS + 1),
    localparam int unsigned IW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    input  logic [DATA_WIDTH:0]   X,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CW-1:0]         err_count,
    output logic [IW-1:0]         first_err_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VECTORS - 1);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [7:0]      settle_cnt;
    logic [DATA_WIDTH:0] expected;
    logic            mismatch;

    function automatic logic [DATA_WIDTH-1:0] op_a(input logic [IW-1:0] i);
        op_a = DATA_WIDTH'(i);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] op_b(input logic [IW-1:0] i);
        int unsigned t;
        t    = 3 * 32'(i) + 1;
        op_b = DATA_WIDTH'(t);
    endfunction

    always_comb begin
        expected = {1'b0, A} + {1'b0, B};
        mismatch = (X != expected);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            settle_cnt    <= '0;
            A             <= '0;
            B             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx           <= '0;
                        A             <= op_a('0);
                        B             <= op_b('0);
                        err_count     <= '0;
                        first_err_idx <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        settle_cnt    <= SETTLE_LOAD;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Leaving on a count of 1 gives exactly SETTLE_CYCLES cycles here.
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt <= 8'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + CW'(1);
                        if (err_count == '0) begin
                            first_err_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        idx        <= idx + IW'(1);
                        A          <= op_a(idx + IW'(1));
                        B          <= op_b(idx + IW'(1));
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_DRIVER_LOG_EN
    always_ff @(posedge clk) begin
        if (rst_n && state == CHECK) begin
            $display("%0t adder_operand_driver idx=%0d A=%0d B=%0d X=%0d exp=%0d %s",
                     $time, idx, A, B, X, expected, mismatch ? "FAIL" : "PASS");
            if (idx == LAST_IDX) begin
                $display("%0t adder_operand_driver run complete errors=%0d",
                         $time, err_count + CW'(mismatch));
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_operand_driver.sv
// Directed bench: a behavioural adder with fault modes feeds dut0 (16 vectors, settle 1);
// dut1 covers the single-vector, settle-3 corner.
module tb_adder_operand_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0: DATA_WIDTH=4, NUM_VECTORS=16, SETTLE_CYCLES=1
    logic       start0 = 1'b0;
    logic [3:0] a0, b0;
    logic [4:0] x0;
    logic       busy0, done0, pass0;
    logic [4:0] err0;
    logic [3:0] first0;

    // dut1: DATA_WIDTH=4, NUM_VECTORS=1, SETTLE_CYCLES=3
    logic       start1 = 1'b0;
    logic [3:0] a1, b1;
    logic [4:0] x1;
    logic       busy1, done1, pass1;
    logic [0:0] err1;
    logic [0:0] first1;

    int xmode = 0;  // 0 correct, 1 X=0 when A==3, 2 X bit 4 stuck at 0
    int total = 0;
    int bad = 0;
    int n;

    adder_operand_driver #(.DATA_WIDTH(4), .NUM_VECTORS(16), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .X(x0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_idx(first0)
    );

    adder_operand_driver #(.DATA_WIDTH(4), .NUM_VECTORS(1), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .X(x1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_idx(first1)
    );

    always_comb begin
        logic [4:0] s;
        s = {1'b0, a0} + {1'b0, b0};
        case (xmode)
            1:       x0 = (a0 == 4'd3) ? 5'd0 : s;
            2:       x0 = {1'b0, s[3:0]};
            default: x0 = s;
        endcase
        x1 = {1'b0, a1} + {1'b0, b1};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse start0, then count clocks until done0 (bounded). Optional spot checks,
    // mid-run start pulses, and a reset at a chosen cycle count.
    task automatic run0(input bit spot, input bit extra, input int rst_at);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        chk("busy_at_start", 32'(busy0), 1);
        chk("done_cleared", 32'(done0), 0);
        if (spot) begin
            chk("v0_A", 32'(a0), 0);
            chk("v0_B", 32'(b0), 1);
            chk("v0_X", 32'(x0), 1);
        end
        while (!done0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            start0 = extra && (n == 5 || n == 11 || n == 20);
            if (spot && n == 6) begin
                chk("v3_A", 32'(a0), 3);
                chk("v3_B", 32'(b0), 10);
                chk("v3_X", 32'(x0), 13);
            end
            if (spot && n == 30) begin
                chk("v15_A", 32'(a0), 15);
                chk("v15_B", 32'(b0), 14);
                chk("v15_X", 32'(x0), 29);
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_A", 32'(a0), 0);
                chk("rst_B", 32'(b0), 0);
                chk("rst_busy", 32'(busy0), 0);
                chk("rst_done", 32'(done0), 0);
                chk("rst_pass", 32'(pass0), 0);
                chk("rst_err", 32'(err0), 0);
                chk("rst_first", 32'(first0), 0);
                return;
            end
        end
        start0 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", 32'(busy0), 0);
        chk("init_done", 32'(done0), 0);
        chk("init_pass", 32'(pass0), 0);
        chk("init_err", 32'(err0), 0);
        chk("init_A", 32'(a0), 0);
        chk("init_B", 32'(b0), 0);
        chk("init_d1_done", 32'(done1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct adder, full run with operand spot checks
        xmode = 0;
        run0(1'b1, 1'b0, -1);
        chk("ok_latency", 32'(n), 32);
        chk("ok_pass", 32'(pass0), 1);
        chk("ok_err", 32'(err0), 0);
        chk("ok_busy", 32'(busy0), 0);

        // Single forced mismatch at vector 3
        xmode = 1;
        run0(1'b0, 1'b0, -1);
        chk("f3_latency", 32'(n), 32);
        chk("f3_err", 32'(err0), 1);
        chk("f3_first", 32'(first0), 3);
        chk("f3_pass", 32'(pass0), 0);
        chk("f3_done", 32'(done0), 1);

        // X bit 4 stuck low: carries at i=4,8,9,10,12,13,14,15
        xmode = 2;
        run0(1'b0, 1'b0, -1);
        chk("sa_latency", 32'(n), 32);
        chk("sa_err", 32'(err0), 8);
        chk("sa_first", 32'(first0), 4);
        chk("sa_pass", 32'(pass0), 0);

        // Restart from DONE with extra start pulses mid-run
        xmode = 0;
        run0(1'b0, 1'b1, -1);
        chk("rs_latency", 32'(n), 32);
        chk("rs_err", 32'(err0), 0);
        chk("rs_first", 32'(first0), 0);
        chk("rs_pass", 32'(pass0), 1);

        // Reset at CHECK of vector 7 (errors already logged), then clean rerun
        xmode = 1;
        run0(1'b0, 1'b0, 15);
        @(negedge clk);
        rst_n = 1'b1;
        xmode = 0;
        run0(1'b1, 1'b0, -1);
        chk("ar_latency", 32'(n), 32);
        chk("ar_err", 32'(err0), 0);
        chk("ar_pass", 32'(pass0), 1);

        // dut1: one vector, settle 3
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        chk("d1_busy", 32'(busy1), 1);
        while (!done1 && n < 50) begin
            if (n < 4) begin
                chk("d1_A", 32'(a1), 0);
                chk("d1_B", 32'(b1), 1);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("d1_latency", 32'(n), 4);
        chk("d1_pass", 32'(pass1), 1);
        chk("d1_err", 32'(err1), 0);
        chk("d1_busy_end", 32'(busy1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
